// File: rtl/bp_fe_queue_rolly_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bp_fe_queue_rolly_pkg                                             |
// | Brief  : Shared constants for the rollback-capable FE->BE queue.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package bp_fe_queue_rolly_pkg;

  // Width of one FE->BE queue entry for the configuration this block is built for.
  localparam int c_fe_queue_width    = 32;

  // Default queue depth; must be a power of two and at least 2.
  localparam int c_fe_queue_fifo_els = 8;

  // Index width that never collapses to zero for tiny depths.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_fe_queue_rolly_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bp_fe_queue_rolly_mem                                             |
// | Brief  : One-write, one-async-read storage array for the queue entries.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bp_fe_queue_rolly_mem #(
  parameter int WIDTH_P = 32,
  parameter int ELS_P   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk_i,
  input  logic               w_v_i,
  input  logic [ADDR_W-1:0]  w_addr_i,
  input  logic [WIDTH_P-1:0] w_data_i,
  input  logic [ADDR_W-1:0]  r_addr_i,
  output logic [WIDTH_P-1:0] r_data_o
);

  logic [WIDTH_P-1:0] r_mem [ELS_P];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      r_mem[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = r_mem[r_addr_i];

endmodule
`default_nettype wire

// File: rtl/bp_fe_queue_rolly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bp_fe_queue_rolly                                                 |
// | Brief  : FE->BE instruction queue with speculative read, commit (deq),     |
// |          replay from oldest uncommitted entry (roll) and flush (clr).      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bp_fe_queue_rolly
  import bp_fe_queue_rolly_pkg::*;
#(
  parameter int ELS_P = c_fe_queue_fifo_els
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [c_fe_queue_width-1:0] fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  output logic [c_fe_queue_width-1:0] fe_queue_o,
  output logic                        fe_queue_v_o,
  input  logic                        fe_queue_yumi_i,
  input  logic                        fe_queue_clr_i,
  input  logic                        fe_queue_deq_i,
  input  logic                        fe_queue_roll_i
);

  localparam int c_width     = c_fe_queue_width;
  localparam int c_idx_width = safe_clog2(ELS_P);
  // Extra MSB is the wrap bit, which lets full and empty be told apart.
  localparam int c_ptr_width = c_idx_width + 1;

  // Write, read (speculative) and commit pointers; commit <= read <= write.
  logic [c_ptr_width-1:0] r_wptr, r_rptr, r_cptr;
  logic [c_ptr_width-1:0] w_wptr_n, w_rptr_n, w_cptr_n;
  logic                   w_full;
  logic                   w_enq;

  // Occupancy counts every entry until it is committed, not just until read.
  assign w_full           = (r_wptr - r_cptr) == c_ptr_width'(ELS_P);
  assign fe_queue_ready_o = ~w_full & ~fe_queue_clr_i;
  assign w_enq            = fe_queue_v_i & fe_queue_ready_o;
  assign fe_queue_v_o     = (r_rptr != r_wptr);

  // Next-pointer rules: commit first, then flush beats replay beats normal flow.
  always_comb begin
    w_cptr_n = r_cptr + c_ptr_width'(fe_queue_deq_i);
    w_rptr_n = r_rptr;
    w_wptr_n = r_wptr;
    if (fe_queue_clr_i) begin
      w_rptr_n = w_cptr_n;
      w_wptr_n = w_cptr_n;
    end else if (fe_queue_roll_i) begin
      w_rptr_n = w_cptr_n;
      w_wptr_n = r_wptr + c_ptr_width'(w_enq);
    end else begin
      w_rptr_n = r_rptr + c_ptr_width'(fe_queue_yumi_i);
      w_wptr_n = r_wptr + c_ptr_width'(w_enq);
    end
  end

  // Pointer registers; reset empties the queue and loses every entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cptr <= w_cptr_n;
    end
  end

  bp_fe_queue_rolly_mem #(
    .WIDTH_P (c_width),
    .ELS_P   (ELS_P),
    .ADDR_W  (c_idx_width)
  ) u_mem (
    .clk_i    (clk_i),
    .w_v_i    (w_enq),
    .w_addr_i (r_wptr[c_idx_width-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (r_rptr[c_idx_width-1:0]),
    .r_data_o (fe_queue_o)
  );

  // Protocol checks on the BE side of the queue.
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_queue_yumi_i && !fe_queue_v_o));

  a_deq_needs_read_entry: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fe_queue_deq_i && (r_cptr == r_rptr)));

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_queue_rolly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bp_fe_queue_rolly                                              |
// | Brief  : Directed vector table plus a randomized reference-queue run.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_bp_fe_queue_rolly;
  import bp_fe_queue_rolly_pkg::*;

  localparam int W = c_fe_queue_width;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i;
  logic         fe_queue_clr_i;
  logic         fe_queue_deq_i;
  logic         fe_queue_roll_i;

  bp_fe_queue_rolly #(.ELS_P(8)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_clr_i   (fe_queue_clr_i),
    .fe_queue_deq_i   (fe_queue_deq_i),
    .fe_queue_roll_i  (fe_queue_roll_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs for one cycle and the outputs expected just before that cycle's edge.
  typedef struct packed {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         yumi;
    logic         deq;
    logic         roll;
    logic         clr;
    logic         ev;
    logic [W-1:0] eo;
    logic         er;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic rst, input logic v, input logic [W-1:0] d,
                              input logic yumi, input logic deq, input logic roll,
                              input logic clr, input logic ev, input logic [W-1:0] eo,
                              input logic er);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.yumi = yumi; x.deq = deq;
    x.roll = roll; x.clr = clr; x.ev = ev; x.eo = eo; x.er = er;
    return x;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [W-1:0] d,
                       input logic yumi, input logic deq, input logic roll, input logic clr);
    reset_i         = rst;
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = yumi;
    fe_queue_deq_i  = deq;
    fe_queue_roll_i = roll;
    fe_queue_clr_i  = clr;
  endtask

  task automatic apply(input vec_t x, input int idx);
    @(negedge clk_i);
    drive(x.rst, x.v, x.d, x.yumi, x.deq, x.roll, x.clr);
    #1;
    n_vec++;
    check($sformatf("vec%0d v_o", idx), W'(fe_queue_v_o), W'(x.ev));
    check($sformatf("vec%0d ready_o", idx), W'(fe_queue_ready_o), W'(x.er));
    if (x.ev) check($sformatf("vec%0d data", idx), fe_queue_o, x.eo);
  endtask

  // Reference model: uncommitted entries oldest-first plus count already read.
  logic [W-1:0] mq[$];
  int           rd;
  int           n_enq;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);

    // Fill 1..8, full behaviour, yumi while full, deq releasing space.
    vecs.push_back(mk(0,0,0,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1,1,    0,0,0,0, 0,0,1));
    for (int k = 2; k <= 8; k++) vecs.push_back(mk(0,1,W'(k), 0,0,0,0, 1,1,1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0, 1,2,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0, 1,3,0));
    vecs.push_back(mk(0,0,0,    0,1,0,0, 1,4,0));
    vecs.push_back(mk(0,1,9,    0,0,0,0, 1,4,1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 1,4,0));
    // Reset mid-operation discards everything.
    vecs.push_back(mk(1,0,0,    0,0,0,0, 1,4,0));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 0,0,1));
    // Read 1..4, commit two, roll: replay starts at 3.
    vecs.push_back(mk(0,1,1,    0,0,0,0, 0,0,1));
    for (int k = 2; k <= 5; k++) vecs.push_back(mk(0,1,W'(k), 0,0,0,0, 1,1,1));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0,0,0, 1,0,0,0, 1,W'(k),1));
    vecs.push_back(mk(0,0,0,    0,1,0,0, 1,5,1));
    vecs.push_back(mk(0,0,0,    0,1,0,0, 1,5,1));
    vecs.push_back(mk(0,0,0,    0,0,1,0, 1,5,1));
    for (int k = 3; k <= 5; k++) vecs.push_back(mk(0,0,0, 1,0,0,0, 1,W'(k),1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 0,0,1));
    // Roll together with deq: oldest (3) is freed, replay starts at 4.
    vecs.push_back(mk(0,1,6,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,    0,1,1,0, 1,6,1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 1,4,1));
    // Clear with 5 uncommitted entries and a valid FE input that must be refused.
    vecs.push_back(mk(0,1,7,    0,0,0,0, 1,4,1));
    vecs.push_back(mk(0,1,8,    0,0,0,0, 1,4,1));
    vecs.push_back(mk(0,1,'hEE, 0,0,0,1, 1,4,0));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1,'hA,  0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 1,'hA,1));
    vecs.push_back(mk(0,0,0,    1,0,0,0, 1,'hA,1));
    vecs.push_back(mk(0,0,0,    0,0,0,0, 0,0,1));

    foreach (vecs[i]) apply(vecs[i], i);

    // Randomized legal traffic against the reference model, starting from reset.
    @(negedge clk_i);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    mq.delete();
    rd    = 0;
    n_enq = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic         m_v, yumi, deq, roll, clr, v, enq, m_ready;
      logic [W-1:0] d;
      m_v     = (rd < mq.size());
      yumi    = m_v && ($urandom_range(1) == 1);
      deq     = (rd > 0) && ($urandom_range(2) == 0);
      roll    = ($urandom_range(15) == 0);
      clr     = ($urandom_range(24) == 0);
      v       = ($urandom_range(3) != 0);
      d       = W'($urandom);
      m_ready = (mq.size() < 8) && !clr;
      drive(1'b0, v, d, yumi, deq, roll, clr);
      #1;
      n_vec++;
      check($sformatf("rnd%0d v_o", cyc), W'(fe_queue_v_o), W'(m_v));
      check($sformatf("rnd%0d ready_o", cyc), W'(fe_queue_ready_o), W'(m_ready));
      if (m_v) check($sformatf("rnd%0d data", cyc), fe_queue_o, mq[rd]);
      enq = v && m_ready;
      if (deq) begin
        void'(mq.pop_front());
        rd--;
      end
      if (clr) begin
        mq.delete();
        rd = 0;
      end else begin
        if (roll) rd = 0;
        else if (yumi) rd++;
        if (enq) begin
          mq.push_back(d);
          n_enq++;
        end
      end
      @(negedge clk_i);
    end
    n_vec++;
    if (n_enq < 24) begin
      n_miss++;
      $display("FAIL wrap_count: got %0d enqueues, expected at least 24", n_enq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
